// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch slice
package fetch_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// rtl/inst_fetch_ctrl_if.sv - ROM, decode and control signals of the fetch sequencer
interface inst_fetch_ctrl_if;
    import fetch_pkg::*;

    logic              Start;
    logic [31:0]       RomAddr;
    logic [INST_W-1:0] RomInst;
    logic [INST_W-1:0] InstOut;
    logic [31:0]       PcOut;
    logic              InstValid;
    logic              InstReady;
    logic              Redirect;
    logic [31:0]       RedirectPc;
    logic              Halted;

    modport master (
        output Start, RomInst, InstReady, Redirect, RedirectPc,
        input  RomAddr, InstOut, PcOut, InstValid, Halted
    );

    modport slave (
        input  Start, RomInst, InstReady, Redirect, RedirectPc,
        output RomAddr, InstOut, PcOut, InstValid, Halted
    );
endinterface

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - 2-entry order-preserving fetch buffer of {pc, inst}
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t ent0_q, ent0_d;
    fetch_entry_t ent1_q, ent1_d;
    logic [1:0]   count_q, count_d;

    // ent0 is always the head; a pop shifts ent1 forward
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush) begin
            ent0_d  = '0;
            ent1_d  = '0;
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = push_entry;
                    else                 ent1_d = push_entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    ent1_d  = '0;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = push_entry;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

    always_comb begin
        head.pc   = 32'h0;
        head.inst = NOP;
        if (count_q != 2'd0) head = ent0_q;
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - PC and fetch FSM feeding decode from a combinational ROM
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_DEPTH = 256,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inst_fetch_ctrl_if.slave     bus
);

    localparam logic [31:0] END_PC = 32'(ROM_DEPTH * 4);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_pc;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_entry;
    logic         pop;
    logic         fetch;
    logic         halted;

    assign redirect_pc = bus.RedirectPc & ~32'h3;

    // a redirect cycle flushes instead of consuming the head
    assign pop = (count != 2'd0) && bus.InstReady && !bus.Redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.Start) state_d = ST_RUN;
            ST_RUN:  if (!bus.Redirect && pc_q >= END_PC) state_d = ST_HALT;
            ST_HALT: if (bus.Redirect) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fetch  = (state_q == ST_RUN) && (pc_q < END_PC) &&
                 ((count < 2'(BUF_DEPTH)) || pop) && !bus.Redirect;
        halted = (state_q == ST_HALT) && (count == 2'd0);
    end

    always_comb begin
        pc_d = pc_q;
        if (bus.Redirect) pc_d = redirect_pc;
        else if (fetch)   pc_d = pc_q + 32'd4;
    end

    assign push_entry.pc   = pc_q;
    assign push_entry.inst = bus.RomInst;

    fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fetch),
        .push_entry (push_entry),
        .pop        (pop && !fetch ? 1'b1 : pop),
        .flush      (bus.Redirect),
        .count      (count),
        .head       (head)
    );

    assign bus.RomAddr   = pc_q;
    assign bus.InstValid = (count != 2'd0);
    assign bus.InstOut   = head.inst;
    assign bus.PcOut     = head.pc;
    assign bus.Halted    = halted;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] rom [4];

    always #5 clk = ~clk;

    inst_fetch_ctrl_if bus ();

    inst_fetch_ctrl #(.RESET_PC(32'h0), .ROM_DEPTH(4), .BUF_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always_comb begin
        bus.RomInst = 32'h0;
        if (bus.RomAddr < 32'h10) bus.RomInst = rom[bus.RomAddr[3:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        bus.Start      = 1'b0;
        bus.InstReady  = 1'b0;
        bus.Redirect   = 1'b0;
        bus.RedirectPc = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic start_pulse();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.InstValid !== 1'b0 || bus.InstOut !== 32'h0 || bus.PcOut !== 32'h0 ||
            bus.Halted !== 1'b0 || bus.RomAddr !== 32'h0) begin
            failures++;
            $display("FAIL reset_values: valid=%b inst=%h pc=%h halted=%b addr=%h, want 0/0/0/0/0",
                     bus.InstValid, bus.InstOut, bus.PcOut, bus.Halted, bus.RomAddr);
        end
        step();
        step();
        checks++;
        if (bus.InstValid !== 1'b0 || bus.RomAddr !== 32'h0) begin
            failures++;
            $display("FAIL idle_no_fetch: valid=%b addr=%h, want 0/0", bus.InstValid, bus.RomAddr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        apply_reset();
        bus.InstReady = 1'b1;
        start_pulse();
        checks++;
        if (bus.InstValid !== 1'b0) begin
            failures++;
            $display("FAIL stream_latency: valid=%b one cycle after start, want 0", bus.InstValid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (bus.InstValid !== 1'b1 || bus.PcOut !== exp_pc[i] || bus.InstOut !== rom[i]) begin
                failures++;
                $display("FAIL stream_%0d: valid=%b pc=%h inst=%h, want 1/%h/%h",
                         i, bus.InstValid, bus.PcOut, bus.InstOut, exp_pc[i], rom[i]);
            end
        end
        step();
        checks++;
        if (bus.Halted !== 1'b1 || bus.InstValid !== 1'b0 || bus.RomAddr !== 32'h10) begin
            failures++;
            $display("FAIL stream_halt: halted=%b valid=%b addr=%h, want 1/0/00000010",
                     bus.Halted, bus.InstValid, bus.RomAddr);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
        apply_reset();
        bus.InstReady = 1'b0;
        start_pulse();
        repeat (4) step();
        checks++;
        if (bus.RomAddr !== 32'h8 || bus.PcOut !== 32'h0 || bus.InstOut !== rom[0]) begin
            failures++;
            $display("FAIL bp_hold: addr=%h pc=%h inst=%h, want 00000008/00000000/%h",
                     bus.RomAddr, bus.PcOut, bus.InstOut, rom[0]);
        end
        bus.InstReady = 1'b1;
        for (int i = 1; i < 3; i++) begin
            step();
            checks++;
            if (bus.InstValid !== 1'b1 || bus.PcOut !== exp_pc[i] || bus.InstOut !== rom[i]) begin
                failures++;
                $display("FAIL bp_drain_%0d: valid=%b pc=%h inst=%h, want 1/%h/%h",
                         i, bus.InstValid, bus.PcOut, bus.InstOut, exp_pc[i], rom[i]);
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        bus.InstReady = 1'b0;
        start_pulse();
        step();
        step();
        bus.Redirect   = 1'b1;
        bus.RedirectPc = 32'h0000_000E;
        step();
        bus.Redirect = 1'b0;
        checks++;
        if (bus.InstValid !== 1'b0 || bus.RomAddr !== 32'hC) begin
            failures++;
            $display("FAIL redir_flush: valid=%b addr=%h, want 0/0000000c", bus.InstValid, bus.RomAddr);
        end
        step();
        checks++;
        if (bus.InstValid !== 1'b1 || bus.PcOut !== 32'hC || bus.InstOut !== rom[3]) begin
            failures++;
            $display("FAIL redir_target: valid=%b pc=%h inst=%h, want 1/0000000c/%h",
                     bus.InstValid, bus.PcOut, bus.InstOut, rom[3]);
        end
    endtask

    task automatic test_run_to_end();
        apply_reset();
        bus.InstReady = 1'b0;
        start_pulse();
        step();
        step();
        bus.InstReady = 1'b1;
        step();
        step();
        checks++;
        if (bus.PcOut !== 32'h8 || bus.InstOut !== rom[2]) begin
            failures++;
            $display("FAIL end_pc8: pc=%h inst=%h, want 00000008/%h", bus.PcOut, bus.InstOut, rom[2]);
        end
        step();
        bus.InstReady = 1'b0;
        checks++;
        if (bus.PcOut !== 32'hC || bus.RomAddr !== 32'h10 || bus.Halted !== 1'b0) begin
            failures++;
            $display("FAIL end_last: pc=%h addr=%h halted=%b, want 0000000c/00000010/0",
                     bus.PcOut, bus.RomAddr, bus.Halted);
        end
        step();
        checks++;
        if (bus.Halted !== 1'b0 || bus.InstValid !== 1'b1 || bus.RomAddr !== 32'h10) begin
            failures++;
            $display("FAIL end_pending: halted=%b valid=%b addr=%h, want 0/1/00000010",
                     bus.Halted, bus.InstValid, bus.RomAddr);
        end
        bus.InstReady = 1'b1;
        step();
        checks++;
        if (bus.Halted !== 1'b1 || bus.InstValid !== 1'b0) begin
            failures++;
            $display("FAIL end_halted: halted=%b valid=%b, want 1/0", bus.Halted, bus.InstValid);
        end
        bus.Redirect   = 1'b1;
        bus.RedirectPc = 32'h0;
        step();
        bus.Redirect = 1'b0;
        checks++;
        if (bus.Halted !== 1'b0 || bus.RomAddr !== 32'h0) begin
            failures++;
            $display("FAIL end_resume: halted=%b addr=%h, want 0/00000000", bus.Halted, bus.RomAddr);
        end
        step();
        checks++;
        if (bus.InstValid !== 1'b1 || bus.PcOut !== 32'h0 || bus.InstOut !== rom[0]) begin
            failures++;
            $display("FAIL end_refetch: valid=%b pc=%h inst=%h, want 1/00000000/%h",
                     bus.InstValid, bus.PcOut, bus.InstOut, rom[0]);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.InstReady = 1'b0;
        start_pulse();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.InstValid !== 1'b0 || bus.InstOut !== 32'h0 || bus.PcOut !== 32'h0 ||
            bus.RomAddr !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: valid=%b inst=%h pc=%h addr=%h, want all 0",
                     bus.InstValid, bus.InstOut, bus.PcOut, bus.RomAddr);
        end
        step();
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.InstValid !== 1'b0 || bus.RomAddr !== 32'h0) begin
            failures++;
            $display("FAIL async_idle: valid=%b addr=%h, want 0/00000000", bus.InstValid, bus.RomAddr);
        end
        start_pulse();
        step();
        checks++;
        if (bus.InstValid !== 1'b1 || bus.PcOut !== 32'h0 || bus.InstOut !== rom[0]) begin
            failures++;
            $display("FAIL async_restart: valid=%b pc=%h inst=%h, want 1/00000000/%h",
                     bus.InstValid, bus.PcOut, bus.InstOut, rom[0]);
        end
    endtask

    task automatic test_redirect_with_ready();
        apply_reset();
        bus.InstReady = 1'b0;
        start_pulse();
        step();
        bus.Redirect   = 1'b1;
        bus.RedirectPc = 32'h8;
        bus.InstReady  = 1'b1;
        step();
        bus.Redirect  = 1'b0;
        bus.InstReady = 1'b0;
        checks++;
        if (bus.InstValid !== 1'b0 || bus.RomAddr !== 32'h8) begin
            failures++;
            $display("FAIL rr_flush: valid=%b addr=%h, want 0/00000008", bus.InstValid, bus.RomAddr);
        end
        step();
        checks++;
        if (bus.InstValid !== 1'b1 || bus.PcOut !== 32'h8 || bus.InstOut !== rom[2]) begin
            failures++;
            $display("FAIL rr_target: valid=%b pc=%h inst=%h, want 1/00000008/%h",
                     bus.InstValid, bus.PcOut, bus.InstOut, rom[2]);
        end
    endtask

    initial begin
        rom[0] = 32'h3401_0005;
        rom[1] = 32'h3402_0003;
        rom[2] = 32'h0022_1820;
        rom[3] = 32'h3C04_ABCD;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_run_to_end();
        test_async_reset();
        test_redirect_with_ready();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
